// File: rtl/disp_chan_sched_pkg.sv
// Shared types and channel constants for the seg7 display channel sequencer.
// Holds the state encoding, the registered status bundle and the scan-advance rule.
package disp_chan_sched_pkg;

   typedef enum logic [1:0] {
      ST_MANUAL = 2'd0,
      ST_SCAN   = 2'd1,
      ST_PAUSED = 2'd2,
      ST_HOLD   = 2'd3
   } state_t;

   typedef struct packed {
      logic scan;
      logic paused;
      logic hold;
   } status_t;

   localparam logic [5:0] CH_LAST_TEST = 6'd7;
   localparam logic [5:0] CH_REG_FIRST = 6'd32;
   localparam logic [5:0] CH_REG_LAST  = 6'd63;

   function automatic status_t status_of(input state_t st);
      status_t s;
      s.scan   = (st == ST_SCAN);
      s.paused = (st == ST_PAUSED);
      s.hold   = (st == ST_HOLD);
      return s;
   endfunction

   // Test channels 0..7, then optionally the register-file slots 32..63, then wrap.
   // Anything outside those ranges (reachable only via the switches) restarts at 0.
   function automatic logic [5:0] next_channel(input logic [5:0] ch, input logic scan_regs);
      if (ch < CH_LAST_TEST)
         return ch + 6'd1;
      else if (ch == CH_LAST_TEST)
         return scan_regs ? CH_REG_FIRST : 6'd0;
      else if (ch >= CH_REG_FIRST && ch < CH_REG_LAST)
         return ch + 6'd1;
      else
         return 6'd0;
   endfunction

endpackage

// File: rtl/disp_chan_sched_btn_debounce.sv
// Push-button conditioner: 2-FF synchronizer, DEB-cycle stability filter,
// and a single-cycle pulse on each accepted rising edge.
module btn_debounce #(
   parameter int DEB = 1_000_000
) (
   input  logic clk,
   input  logic rst,
   input  logic raw,
   output logic pulse
);

   localparam int CW = $clog2(DEB + 1);
   localparam logic [CW-1:0] CNT_LAST = CW'(DEB - 1);

   logic          raw_s1;
   logic          raw_s2;
   logic          level;
   logic [CW-1:0] cnt;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         raw_s1 <= 1'b0;
         raw_s2 <= 1'b0;
         level  <= 1'b0;
         cnt    <= '0;
         pulse  <= 1'b0;
      end else begin
         // NOTE: non-blocking here so raw_s2 takes the old raw_s1, giving a true 2-stage synchronizer.
         raw_s1 <= raw;
         raw_s2 <= raw_s1;
         pulse  <= 1'b0;
         // The counter tracks consecutive cycles the synced input disagrees with the accepted level.
         if (raw_s2 == level) begin
            cnt <= '0;
         end else if (cnt == CNT_LAST) begin
            level <= raw_s2;
            cnt   <= '0;
            pulse <= raw_s2;
         end else begin
            cnt <= cnt + CW'(1);
         end
      end
   end

endmodule

// File: rtl/disp_chan_sched.sv
// Channel-select sequencer for the seg7 display mux: manual follow, dwell-timed
// auto-scan, paused single-step, and a CPU-write hold that forces channel 0.
module disp_chan_sched
   import disp_chan_sched_pkg::*;
#(
   parameter int DWELL     = 50_000_000,
   parameter int DEB       = 1_000_000,
   parameter int HOLD_CYC  = 100_000_000,
   parameter int SCAN_REGS = 1
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [5:0] sw,
   input  logic       mode_auto,
   input  logic       btn_next,
   input  logic       btn_pause,
   input  logic       cpu_wr,
   output logic [5:0] ctrl_out,
   output logic       scan_active,
   output logic       paused,
   output logic       hold_active
);

   localparam int DW = $clog2(DWELL);
   localparam int HW = (HOLD_CYC > 0) ? $clog2(HOLD_CYC + 1) : 1;
   localparam logic [DW-1:0] DWELL_LAST = DW'(DWELL - 1);
   localparam logic [HW-1:0] HOLD_LOAD  = (HOLD_CYC > 0) ? HW'(HOLD_CYC - 1) : '0;
   localparam logic          HOLD_EN    = (HOLD_CYC > 0);
   localparam logic          REGS_EN    = (SCAN_REGS != 0);

   logic [5:0]    sw_s1;
   logic [5:0]    sw_sync;
   logic          mode_s1;
   logic          mode_sync;
   logic          next_pulse;
   logic          pause_pulse;

   state_t        state;
   state_t        saved_state;
   status_t       status;
   logic [5:0]    saved_ch;
   logic [DW-1:0] dwell_cnt;
   logic [HW-1:0] hold_cnt;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sw_s1     <= '0;
         sw_sync   <= '0;
         mode_s1   <= 1'b0;
         mode_sync <= 1'b0;
      end else begin
         sw_s1     <= sw;
         sw_sync   <= sw_s1;
         mode_s1   <= mode_auto;
         mode_sync <= mode_s1;
      end
   end

   btn_debounce #(.DEB(DEB)) u_deb_next (
      .clk   (clk),
      .rst   (rst),
      .raw   (btn_next),
      .pulse (next_pulse)
   );

   btn_debounce #(.DEB(DEB)) u_deb_pause (
      .clk   (clk),
      .rst   (rst),
      .raw   (btn_pause),
      .pulse (pause_pulse)
   );

   // Status flags are registered together with state so they line up with ctrl_out.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state       <= ST_MANUAL;
         status      <= status_of(ST_MANUAL);
         saved_state <= ST_MANUAL;
         saved_ch    <= '0;
         ctrl_out    <= '0;
         dwell_cnt   <= '0;
         hold_cnt    <= '0;
      end else if (cpu_wr && HOLD_EN) begin
         // A retrigger only reloads the timer; the pre-hold context stays as first saved.
         if (state != ST_HOLD) begin
            saved_state <= state;
            saved_ch    <= ctrl_out;
         end
         state    <= ST_HOLD;
         status   <= status_of(ST_HOLD);
         ctrl_out <= '0;
         hold_cnt <= HOLD_LOAD;
      end else begin
         case (state)
            ST_MANUAL: begin
               if (mode_sync) begin
                  state     <= ST_SCAN;
                  status    <= status_of(ST_SCAN);
                  ctrl_out  <= '0;
                  dwell_cnt <= '0;
               end else begin
                  ctrl_out <= sw_sync;
               end
            end

            ST_SCAN: begin
               if (!mode_sync) begin
                  state    <= ST_MANUAL;
                  status   <= status_of(ST_MANUAL);
                  ctrl_out <= sw_sync;
               end else if (pause_pulse) begin
                  state  <= ST_PAUSED;
                  status <= status_of(ST_PAUSED);
               end else if (next_pulse || dwell_cnt == DWELL_LAST) begin
                  ctrl_out  <= next_channel(ctrl_out, REGS_EN);
                  dwell_cnt <= '0;
               end else begin
                  dwell_cnt <= dwell_cnt + DW'(1);
               end
            end

            ST_PAUSED: begin
               if (!mode_sync) begin
                  state    <= ST_MANUAL;
                  status   <= status_of(ST_MANUAL);
                  ctrl_out <= sw_sync;
               end else if (pause_pulse) begin
                  state     <= ST_SCAN;
                  status    <= status_of(ST_SCAN);
                  dwell_cnt <= '0;
               end else if (next_pulse) begin
                  ctrl_out <= next_channel(ctrl_out, REGS_EN);
               end
            end

            ST_HOLD: begin
               // Button pulses are deliberately ignored while the CPU value is on show.
               if (hold_cnt == '0) begin
                  state     <= saved_state;
                  status    <= status_of(saved_state);
                  dwell_cnt <= '0;
                  ctrl_out  <= (saved_state == ST_MANUAL) ? sw_sync : saved_ch;
               end else begin
                  hold_cnt <= hold_cnt - HW'(1);
               end
            end

            default: begin
               state  <= ST_MANUAL;
               status <= status_of(ST_MANUAL);
            end
         endcase
      end
   end

   assign scan_active = status.scan;
   assign paused      = status.paused;
   assign hold_active = status.hold;

endmodule

// File: tb/tb_disp_chan_sched.sv
// Randomized self-checking bench for disp_chan_sched against a time-based
// behavioural model (event timestamps instead of counters).
module tb_disp_chan_sched;

   localparam int DWELL     = 4;
   localparam int DEB       = 3;
   localparam int HOLD_CYC  = 5;
   localparam int SCAN_REGS = 1;

   localparam int S_MAN   = 0;
   localparam int S_SCAN  = 1;
   localparam int S_PAUSE = 2;
   localparam int S_HOLD  = 3;

   logic       clk = 1'b0;
   logic       rst;
   logic [5:0] sw;
   logic       mode_auto;
   logic       btn_next;
   logic       btn_pause;
   logic       cpu_wr;
   logic [5:0] ctrl_out;
   logic       scan_active;
   logic       paused;
   logic       hold_active;

   int n_checks = 0;
   int n_fail   = 0;

   disp_chan_sched #(
      .DWELL     (DWELL),
      .DEB       (DEB),
      .HOLD_CYC  (HOLD_CYC),
      .SCAN_REGS (SCAN_REGS)
   ) u_dut (
      .clk         (clk),
      .rst         (rst),
      .sw          (sw),
      .mode_auto   (mode_auto),
      .btn_next    (btn_next),
      .btn_pause   (btn_pause),
      .cpu_wr      (cpu_wr),
      .ctrl_out    (ctrl_out),
      .scan_active (scan_active),
      .paused      (paused),
      .hold_active (hold_active)
   );

   always #5 clk = ~clk;

   initial begin
      #1_000_000;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=%0d exp=%0d at %0t", tag, got, exp, $time);
      end
   endtask

   // ---------------- reference model ----------------
   int   t;
   int   m_st, m_ch, m_sv_st, m_sv_ch;
   int   m_dwell_start, m_hold_end;
   int   m_sw1, m_sw2;
   bit   m_md1, m_md2;
   bit   m_b1[2], m_b2[2], m_acc[2], m_pl[2];
   bit   m_hist[2][DEB];

   function automatic int adv(input int c);
      if (c < 7)              return c + 1;
      if (c == 7)             return (SCAN_REGS != 0) ? 32 : 0;
      if (c >= 32 && c < 63)  return c + 1;
      return 0;
   endfunction

   task automatic model_reset();
      m_st = S_MAN; m_ch = 0; m_sv_st = S_MAN; m_sv_ch = 0;
      m_dwell_start = t; m_hold_end = t;
      m_sw1 = 0; m_sw2 = 0; m_md1 = 0; m_md2 = 0;
      for (int b = 0; b < 2; b++) begin
         m_b1[b] = 0; m_b2[b] = 0; m_acc[b] = 0; m_pl[b] = 0;
         for (int i = 0; i < DEB; i++) m_hist[b][i] = 0;
      end
   endtask

   task automatic model_edge();
      bit raw[2];
      bit all_flip;
      t++;
      if (cpu_wr && HOLD_CYC > 0) begin
         if (m_st != S_HOLD) begin
            m_sv_st = m_st;
            m_sv_ch = m_ch;
         end
         m_st = S_HOLD;
         m_ch = 0;
         m_hold_end = t + HOLD_CYC;
      end else if (m_st == S_MAN) begin
         if (m_md2) begin
            m_st = S_SCAN; m_ch = 0; m_dwell_start = t;
         end else m_ch = m_sw2;
      end else if (m_st == S_SCAN) begin
         if (!m_md2) begin
            m_st = S_MAN; m_ch = m_sw2;
         end else if (m_pl[1]) m_st = S_PAUSE;
         else if (m_pl[0] || (t - m_dwell_start) == DWELL) begin
            m_ch = adv(m_ch); m_dwell_start = t;
         end
      end else if (m_st == S_PAUSE) begin
         if (!m_md2) begin
            m_st = S_MAN; m_ch = m_sw2;
         end else if (m_pl[1]) begin
            m_st = S_SCAN; m_dwell_start = t;
         end else if (m_pl[0]) m_ch = adv(m_ch);
      end else begin
         if (t == m_hold_end) begin
            m_st = m_sv_st;
            m_ch = (m_sv_st == S_MAN) ? m_sw2 : m_sv_ch;
            m_dwell_start = t;
         end
      end

      // Button accepted once the last DEB synchronized samples all disagree with the current level.
      raw[0] = btn_next;
      raw[1] = btn_pause;
      for (int b = 0; b < 2; b++) begin
         for (int i = DEB - 1; i > 0; i--) m_hist[b][i] = m_hist[b][i-1];
         m_hist[b][0] = m_b2[b];
         all_flip = 1;
         for (int i = 0; i < DEB; i++) if (m_hist[b][i] == m_acc[b]) all_flip = 0;
         m_pl[b] = 0;
         if (all_flip) begin
            m_acc[b] = ~m_acc[b];
            m_pl[b]  = m_acc[b];
            for (int i = 0; i < DEB; i++) m_hist[b][i] = m_acc[b];
         end
         m_b2[b] = m_b1[b];
         m_b1[b] = raw[b];
      end
      m_sw2 = m_sw1; m_sw1 = int'(sw);
      m_md2 = m_md1; m_md1 = mode_auto;
   endtask

   // ---------------- stimulus helpers ----------------
   task automatic tick();
      @(posedge clk);
      model_edge();
      @(negedge clk);
      check("ctrl_out", 32'(ctrl_out), m_ch);
      check("status", {29'd0, scan_active, paused, hold_active},
            {29'd0, m_st == S_SCAN, m_st == S_PAUSE, m_st == S_HOLD});
   endtask

   task automatic do_reset();
      rst = 1'b1;
      model_reset();
      #1;
      check("rst_async_ctrl", 32'(ctrl_out), 0);
      check("rst_async_status", {29'd0, scan_active, paused, hold_active}, 0);
      @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic set_btn(input int which, input logic v);
      if (which == 0) btn_next = v;
      else            btn_pause = v;
   endtask

   task automatic press(input int which, input int n);
      set_btn(which, 1'b1);
      repeat (n) tick();
      set_btn(which, 1'b0);
      repeat (n) tick();
   endtask

   task automatic wait_scan_ch(input int ch);
      for (int i = 0; i < 400 && !(m_ch == ch && m_st == S_SCAN); i++) tick();
      check("wait_scan_ch", (m_ch == ch && m_st == S_SCAN), 1);
   endtask

   initial begin
      int p;
      t = 0;
      rst = 1'b0; sw = '0; mode_auto = 1'b0;
      btn_next = 1'b0; btn_pause = 1'b0; cpu_wr = 1'b0;
      #2 rst = 1'b1;
      model_reset();
      repeat (2) @(negedge clk);
      check("reset_ctrl", 32'(ctrl_out), 0);
      check("reset_scan", 32'(scan_active), 0);
      check("reset_paused", 32'(paused), 0);
      check("reset_hold", 32'(hold_active), 0);
      rst = 1'b0;

      // Manual follow latency
      sw = 6'd5;
      repeat (2) tick();
      check("sw_early", 32'(ctrl_out), 0);
      tick();
      check("sw_latency", 32'(ctrl_out), 5);

      // Full auto-scan lap
      mode_auto = 1'b1;
      repeat (175) tick();

      // Pause, single step, resume
      wait_scan_ch(3);
      press(1, 8);
      check("pause_flag", 32'(paused), 1);
      p = m_ch;
      press(0, 8);
      check("pause_step", 32'(ctrl_out), adv(p));
      press(1, 8);
      check("resume_flag", 32'(scan_active), 1);

      // CPU-write hold from index 7 and its retrigger
      wait_scan_ch(7);
      cpu_wr = 1'b1;
      for (int i = 0; i < HOLD_CYC; i++) begin
         tick();
         cpu_wr = 1'b0;
         check("hold_ch", 32'(ctrl_out), 0);
         check("hold_flag", 32'(hold_active), 1);
      end
      tick();
      check("hold_restore", 32'(ctrl_out), 7);
      cpu_wr = 1'b1;
      repeat (3) begin
         tick();
         cpu_wr = 1'b0;
      end
      cpu_wr = 1'b1;
      for (int i = 0; i < HOLD_CYC; i++) begin
         tick();
         cpu_wr = 1'b0;
         check("hold2_ch", 32'(ctrl_out), 0);
      end
      tick();
      check("hold2_restore", 32'(ctrl_out), 7);
      check("hold2_scan", 32'(scan_active), 1);

      // Bounced next press while paused -> single advance
      press(1, 8);
      p = m_ch;
      for (int i = 0; i < 10; i++) begin
         btn_next = ~btn_next;
         tick();
      end
      press(0, 8);
      check("bounce_step", 32'(ctrl_out), adv(p));
      check("bounce_paused", 32'(paused), 1);

      // Next pulses at every dwell phase, including coincidence with expiry
      press(1, 8);
      for (int off = 0; off < DWELL; off++) begin
         repeat (off) tick();
         press(0, 6);
      end

      // Reset during HOLD and during a debounce in progress
      cpu_wr = 1'b1;
      tick();
      cpu_wr = 1'b0;
      tick();
      do_reset();
      check("rst_hold_state", 32'(hold_active), 0);
      repeat (10) tick();
      btn_next = 1'b1;
      repeat (3) tick();
      btn_next = 1'b0;
      do_reset();
      repeat (30) tick();

      // Randomized traffic
      for (int i = 0; i < 3000; i++) begin
         if ($urandom_range(0, 19) == 0) sw = 6'($urandom);
         if ($urandom_range(0, 249) == 0) mode_auto = ~mode_auto;
         if ($urandom_range(0, 7) == 0) btn_next = ~btn_next;
         if ($urandom_range(0, 9) == 0) btn_pause = ~btn_pause;
         cpu_wr = ($urandom_range(0, 59) == 0);
         if ($urandom_range(0, 1499) == 0) do_reset();
         tick();
      end

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
